instr_mem: RTL and testbench

Instruction memory and program loader that responds to the CPU core's fetch port. It accepts a program word-by-word over a valid/ready load stream, then serves single-cycle-latency reads on `instr_addr`/`instr_data`. It also drives `last_pc`, so the core's PC stops at the final loaded instruction. It sits beside `core` in the top level: `instr_addr` comes in from the core, and `instr_data` and `last_pc` go out to it.

---
 rtl/instr_mem.sv | 124 ++++++++++++
 tb/tb_instr_mem.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory with valid/ready program loader and 1-cycle fetch port
// Optional load checksum accumulator: define INSTR_MEM_CHECKSUM_EN.
module instr_mem #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        reload,
  output logic        run,
  output logic [31:0] ld_checksum
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              final_word;
  logic              reload_go;
  logic              fetch_hit;

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    accept     = 1'b0;
    final_word = 1'b0;
    reload_go  = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        accept   = ld_valid;
        // The top slot ends the load on its own so the pointer never wraps onto word 0.
        final_word = ld_valid && (ld_last || (wr_ptr == {ADDR_W{1'b1}}));
        if (final_word) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        reload_go = reload;
        if (reload) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      wr_ptr  <= '0;
      last_pc <= '1;
      run     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (final_word) begin
        last_pc <= {{(32 - ADDR_W){1'b0}}, wr_ptr};
        run     <= 1'b1;
      end else if (reload_go) begin
        wr_ptr  <= '0;
        last_pc <= '1;
        run     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= ld_data;
    end
  end

  // Anything outside the resident program reads as a NOP, including the core's reset PC.
  assign fetch_hit = (state == RUN) &&
                     (instr_addr[31:ADDR_W] == '0) &&
                     (instr_addr[ADDR_W-1:0] <= last_pc[ADDR_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_data <= NOP_WORD;
    end else if (fetch_hit) begin
      instr_data <= mem[instr_addr[ADDR_W-1:0]];
    end else begin
      instr_data <= NOP_WORD;
    end
  end

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (reload_go) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + ld_data;
    end
  end

  assign ld_checksum = sum_q;
`else
  assign ld_checksum = '0;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - randomized scoreboard bench for instr_mem against a word-level program model
module tb_instr_mem;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic [31:0] last_pc;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;
  logic        run;
  logic [31:0] ld_checksum;

  instr_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .last_pc     (last_pc),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .reload      (reload),
    .run         (run),
    .ld_checksum (ld_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Program model: resident words, index of last word (-1 = none), running sum.
  logic [31:0] m_mem [DEPTH];
  int          m_last;
  int          m_wp;
  bit          m_run;
  logic [31:0] m_sum;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] act;

  function automatic string kname(input int k);
    case (k)
      0: return "instr_data";
      1: return "last_pc";
      2: return "run";
      3: return "ld_ready";
      default: return "ld_checksum";
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0: act = instr_data;
        1: act = last_pc;
        2: act = {31'b0, run};
        3: act = {31'b0, ld_ready};
        default: act = ld_checksum;
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h at cycle %0d", kname(e.kind), act, e.exp, cyc);
      end
    end
  end

  task automatic push(input int k, input logic [31:0] x, input int due);
    exp_t t;
    t.kind = k;
    t.exp  = x;
    t.due  = due;
    q.push_back(t);
  endtask

  function automatic logic [31:0] fetch_exp(input logic [31:0] a);
    if (!m_run || a >= 32'(DEPTH) || int'(a) > m_last) return NOP;
    return m_mem[a[7:0]];
  endfunction

  task automatic push_state(input int due);
    push(1, m_run ? 32'(m_last) : 32'hFFFFFFFF, due);
    push(2, {31'b0, m_run}, due);
    push(3, {31'b0, !m_run}, due);
`ifdef INSTR_MEM_CHECKSUM_EN
    push(4, m_sum, due);
`else
    push(4, 32'h0, due);
`endif
  endtask

  // One clock of stimulus; called and returns at posedge+1.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit rl,
                      input logic [31:0] a);
    ld_valid   = v;
    ld_data    = d;
    ld_last    = l;
    reload     = rl;
    instr_addr = a;
    push(0, fetch_exp(a), cyc + 1);
    if (!m_run) begin
      if (v) begin
        m_mem[m_wp] = d;
        m_sum = m_sum + d;
        if (l || m_wp == DEPTH - 1) begin
          m_run  = 1'b1;
          m_last = m_wp;
        end
        m_wp++;
      end
    end else if (rl) begin
      m_run  = 1'b0;
      m_last = -1;
      m_wp   = 0;
      m_sum  = '0;
    end
    push_state(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_run  = 1'b0;
    m_last = -1;
    m_wp   = 0;
    m_sum  = '0;
  endtask

  // Reset lands between edges; checks due this cycle prove it acts without a clock.
  task automatic do_reset();
    ld_valid = 1'b0;
    reload   = 1'b0;
    rst_n    = 1'b0;
    model_clear();
    push(0, NOP, cyc);
    push_state(cyc);
    @(posedge clk);
    #1;
    push(0, NOP, cyc);
    push_state(cyc);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'hFFFFFFFF;
      1: return 32'h00000100 + $urandom_range(0, 32'h0FFFFFFF);
      2: return 32'($urandom_range(0, DEPTH - 1));
      default: return (m_last >= 0) ? 32'($urandom_range(0, m_last + 2)) : 32'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic load_words(input int n, input bit with_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct)
        step(1'b0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), rand_addr());
      step(1'b1, $urandom, with_last && (i == n - 1), 1'b0, rand_addr());
    end
  endtask

  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, rand_addr());
  endtask

  initial begin
    rst_n      = 1'b0;
    instr_addr = 32'hFFFFFFFF;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    reload     = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // A,B,C with ld_last on C, then directed fetches including out-of-range.
    step(1'b1, 32'hA0A0A0A0, 1'b0, 1'b0, 32'hFFFFFFFF);
    step(1'b1, 32'hB1B1B1B1, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'hC2C2C2C2, 1'b1, 1'b0, 32'h1);
    for (int a = 0; a < 4; a++) step(1'b0, '0, 1'b0, 1'b0, 32'(a));
    step(1'b0, '0, 1'b0, 1'b0, 32'hFFFFFFFF);
    step(1'b0, '0, 1'b0, 1'b0, 32'h00000100);
    step(1'b1, 32'h5555AAAA, 1'b1, 1'b0, 32'h0);

    // Reload then single-word program.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0);
    fetch_n(2);
    step(1'b1, 32'hD00DD00D, 1'b1, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, 32'h1);

    // Valid toggling 1,0,1,1 with data 1,X,2,3.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'd1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'd2, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'd3, 1'b1, 1'b0, 32'h0);
    for (int a = 0; a < 4; a++) step(1'b0, '0, 1'b0, 1'b0, 32'(a));

    // Full depth without ld_last; the extra word must not land on word 0.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0);
    load_words(DEPTH, 1'b0, 0);
    step(1'b1, 32'hFEEDFACE, 1'b0, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, 32'hFF);
    fetch_n(10);

    // Reset after 2 of 4 words, then a clean 4-word load.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0);
    load_words(2, 1'b0, 0);
    do_reset();
    load_words(4, 1'b1, 0);
    for (int a = 0; a < 5; a++) step(1'b0, '0, 1'b0, 1'b0, 32'(a));

    // Random programs with gaps and random fetches.
    for (int r = 0; r < 20; r++) begin
      step(1'b0, '0, 1'b0, 1'b1, rand_addr());
      load_words($urandom_range(1, 40), 1'b1, 30);
      fetch_n(15);
    end

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
